// File: rtl/parking_pkg.sv
// Shared types and constants for the parking gate decoder.
package parking_pkg;

  localparam int DEFAULT_CAPACITY = 7;

  typedef enum logic [2:0] {
    IDLE,
    IN1,
    IN2,
    IN3,
    OUT1,
    OUT2,
    OUT3,
    WAIT_CLEAR
  } gate_state_e;

endpackage

// File: rtl/occupancy_counter.sv
// Saturating 3-bit occupancy counter; ovf flags an increment while full or a
// decrement while empty (the count holds in both cases).
module occupancy_counter
  import parking_pkg::*;
#(
  parameter int CAPACITY = DEFAULT_CAPACITY
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       inc,
  input  logic       dec,
  output logic [2:0] count,
  output logic       full,
  output logic       empty,
  output logic       ovf
);

  localparam logic [2:0] CAP = 3'(CAPACITY);

  logic [2:0] count_q;
  logic [2:0] count_d;

  assign full  = (count_q == CAP);
  assign empty = (count_q == 3'd0);
  assign count = count_q;
  assign ovf   = (inc && full) || (dec && empty);

  always_comb begin
    count_d = count_q;
    if (inc && !full) begin
      count_d = count_q + 3'd1;
    end else if (dec && !empty) begin
      count_d = count_q - 3'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= 3'd0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/parking_gate_decoder.sv
// Two-beam parking gate decoder: tracks the a/b beam sequence, counts cars in
// and out. Define PARK_GATE_SYNC_EN to add a 2-flop synchronizer per sensor.
module parking_gate_decoder
  import parking_pkg::*;
#(
  parameter int CAPACITY = DEFAULT_CAPACITY
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sensor_a,
  input  logic       sensor_b,
  output logic [2:0] count,
  output logic       full,
  output logic       empty,
  output logic       enter_pulse,
  output logic       exit_pulse,
  output logic       err
);

  logic [1:0] ab;

`ifdef PARK_GATE_SYNC_EN
  logic [1:0] sensors;
  logic [1:0] sync1_q;
  logic [1:0] sync2_q;

  assign sensors = {sensor_a, sensor_b};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_sync
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          sync1_q[gi] <= 1'b0;
          sync2_q[gi] <= 1'b0;
        end else begin
          sync1_q[gi] <= sensors[gi];
          sync2_q[gi] <= sync1_q[gi];
        end
      end
    end
  endgenerate

  assign ab = sync2_q;
`else
  assign ab = {sensor_a, sensor_b};
`endif

  gate_state_e state_q;
  gate_state_e state_d;
  logic        entry_ev;
  logic        exit_ev;
  logic        illegal;
  logic        ovf;
  logic        enter_pulse_q;
  logic        enter_pulse_d;
  logic        exit_pulse_q;
  logic        exit_pulse_d;
  logic        err_q;
  logic        err_d;

  // Entry walks a -> ab -> b -> clear; exit is the mirror image.
  always_comb begin
    state_d  = state_q;
    entry_ev = 1'b0;
    exit_ev  = 1'b0;
    illegal  = 1'b0;
    case (state_q)
      IDLE: begin
        case (ab)
          2'b10:   state_d = IN1;
          2'b01:   state_d = OUT1;
          2'b11:   begin state_d = WAIT_CLEAR; illegal = 1'b1; end
          default: state_d = IDLE;
        endcase
      end
      IN1: begin
        case (ab)
          2'b10:   state_d = IN1;
          2'b11:   state_d = IN2;
          2'b00:   state_d = IDLE;
          default: begin state_d = WAIT_CLEAR; illegal = 1'b1; end
        endcase
      end
      IN2: begin
        case (ab)
          2'b11:   state_d = IN2;
          2'b01:   state_d = IN3;
          2'b10:   state_d = IN1;
          default: begin state_d = WAIT_CLEAR; illegal = 1'b1; end
        endcase
      end
      IN3: begin
        case (ab)
          2'b01:   state_d = IN3;
          2'b11:   state_d = IN2;
          2'b00:   begin state_d = IDLE; entry_ev = 1'b1; end
          default: begin state_d = WAIT_CLEAR; illegal = 1'b1; end
        endcase
      end
      OUT1: begin
        case (ab)
          2'b01:   state_d = OUT1;
          2'b11:   state_d = OUT2;
          2'b00:   state_d = IDLE;
          default: begin state_d = WAIT_CLEAR; illegal = 1'b1; end
        endcase
      end
      OUT2: begin
        case (ab)
          2'b11:   state_d = OUT2;
          2'b10:   state_d = OUT3;
          2'b01:   state_d = OUT1;
          default: begin state_d = WAIT_CLEAR; illegal = 1'b1; end
        endcase
      end
      OUT3: begin
        case (ab)
          2'b10:   state_d = OUT3;
          2'b11:   state_d = OUT2;
          2'b00:   begin state_d = IDLE; exit_ev = 1'b1; end
          default: begin state_d = WAIT_CLEAR; illegal = 1'b1; end
        endcase
      end
      WAIT_CLEAR: begin
        if (ab == 2'b00) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  occupancy_counter #(
    .CAPACITY(CAPACITY)
  ) u_occupancy_counter (
    .clk  (clk),
    .reset(reset),
    .inc  (entry_ev),
    .dec  (exit_ev),
    .count(count),
    .full (full),
    .empty(empty),
    .ovf  (ovf)
  );

  always_comb begin
    enter_pulse_d = entry_ev;
    exit_pulse_d  = exit_ev;
    err_d         = illegal || ovf;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      enter_pulse_q <= 1'b0;
      exit_pulse_q  <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      enter_pulse_q <= enter_pulse_d;
      exit_pulse_q  <= exit_pulse_d;
      err_q         <= err_d;
    end
  end

  assign enter_pulse = enter_pulse_q;
  assign exit_pulse  = exit_pulse_q;
  assign err         = err_q;

endmodule

// File: tb/tb_parking_gate_decoder.sv
// Scoreboard bench for parking_gate_decoder: expected per-cycle outputs are
// queued as sensor patterns are driven and checked as the DUT responds.
module tb_parking_gate_decoder;

  localparam int CAP = 7;
`ifdef PARK_GATE_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  typedef enum int {EV_NONE, EV_ENTRY, EV_EXIT, EV_ILL} ev_e;

  typedef struct {
    int count;
    int enter;
    int exit_p;
    int err;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       sensor_a;
  logic       sensor_b;
  logic [2:0] count;
  logic       full;
  logic       empty;
  logic       enter_pulse;
  logic       exit_pulse;
  logic       err;

  exp_t sb[$];
  exp_t mon_e;
  int   tests_run    = 0;
  int   tests_failed = 0;
  int   exp_count    = 0;
  bit   prefill      = 1'b0;

  parking_gate_decoder #(
    .CAPACITY(CAP)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .sensor_a   (sensor_a),
    .sensor_b   (sensor_b),
    .count      (count),
    .full       (full),
    .empty      (empty),
    .enter_pulse(enter_pulse),
    .exit_pulse (exit_pulse),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    tests_run++;
    if (got != exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (reset && sb.size() > 0) begin
      mon_e = sb.pop_front();
      check_eq("count", int'(count), mon_e.count);
      check_eq("enter_pulse", int'(enter_pulse), mon_e.enter);
      check_eq("exit_pulse", int'(exit_pulse), mon_e.exit_p);
      check_eq("err", int'(err), mon_e.err);
      check_eq("full", int'(full), (mon_e.count == CAP) ? 1 : 0);
      check_eq("empty", int'(empty), (mon_e.count == 0) ? 1 : 0);
      $display("[TB] txn count=%0d enter=%0d exit=%0d err=%0d full=%0d empty=%0d",
               count, enter_pulse, exit_pulse, err, full, empty);
    end
  end

  task automatic step(input logic [1:0] ab, input ev_e ev);
    exp_t e;
    @(negedge clk);
    if (prefill) begin
      for (int i = 0; i < LAT; i++) sb.push_back('{exp_count, 0, 0, 0});
      prefill = 1'b0;
    end
    sensor_a = ab[1];
    sensor_b = ab[0];
    e = '{0, 0, 0, 0};
    case (ev)
      EV_ENTRY: begin
        e.enter = 1;
        if (exp_count == CAP) e.err = 1;
        else exp_count++;
      end
      EV_EXIT: begin
        e.exit_p = 1;
        if (exp_count == 0) e.err = 1;
        else exp_count--;
      end
      EV_ILL: e.err = 1;
      default: ;
    endcase
    e.count = exp_count;
    sb.push_back(e);
  endtask

  task automatic car_in();
    step(2'b10, EV_NONE);
    step(2'b11, EV_NONE);
    step(2'b01, EV_NONE);
    step(2'b00, EV_ENTRY);
  endtask

  task automatic car_out();
    step(2'b01, EV_NONE);
    step(2'b11, EV_NONE);
    step(2'b10, EV_NONE);
    step(2'b00, EV_EXIT);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
    #2;
    check_eq("sb_drain", sb.size(), 0);
  endtask

  task automatic release_reset();
    sensor_a = 1'b0;
    sensor_b = 1'b0;
    @(negedge clk);
    reset     = 1'b1;
    exp_count = 0;
    prefill   = 1'b1;
  endtask

  initial begin
    reset    = 1'b0;
    sensor_a = 1'b0;
    sensor_b = 1'b0;
    #12;
    check_eq("rst_count", int'(count), 0);
    check_eq("rst_empty", int'(empty), 1);
    check_eq("rst_full", int'(full), 0);
    check_eq("rst_enter", int'(enter_pulse), 0);
    check_eq("rst_exit", int'(exit_pulse), 0);
    check_eq("rst_err", int'(err), 0);
    release_reset();

    // Plain entry from reset, then fill to 3 and let one car out.
    step(2'b00, EV_NONE);
    car_in();
    car_in();
    car_in();
    car_out();

    // Car backs out of the gate: no event.
    step(2'b10, EV_NONE);
    step(2'b11, EV_NONE);
    step(2'b10, EV_NONE);
    step(2'b00, EV_NONE);

    // Both beams at once from IDLE, then a legal entry.
    step(2'b00, EV_NONE);
    step(2'b11, EV_ILL);
    step(2'b11, EV_NONE);
    step(2'b00, EV_NONE);
    car_in();

    // Illegal jump from IN1; WAIT_CLEAR swallows everything until clear.
    step(2'b10, EV_NONE);
    step(2'b01, EV_ILL);
    step(2'b11, EV_NONE);
    step(2'b01, EV_NONE);
    step(2'b00, EV_NONE);

    // Reset in the middle of an entry at count 4.
    car_in();
    step(2'b10, EV_NONE);
    step(2'b11, EV_NONE);
    drain();
    reset = 1'b0;
    #1;
    check_eq("midrst_count", int'(count), 0);
    check_eq("midrst_empty", int'(empty), 1);
    check_eq("midrst_full", int'(full), 0);
    check_eq("midrst_enter", int'(enter_pulse), 0);
    check_eq("midrst_err", int'(err), 0);
    #7;
    release_reset();

    // Exit while empty underflows; then fill past capacity.
    car_out();
    for (int i = 0; i < 8; i++) car_in();
    car_out();
    car_in();
    step(2'b00, EV_NONE);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
